// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a synchronous imem, presents one instruction (with its PC) per cycle.
// Fetch latency 1 cycle; a taken branch costs exactly one NOP bubble; stall freezes all state and the memory.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_en,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  take;

  assign instr_valid = (state == RUN);
  assign imem_addr   = pc;
  assign imem_en     = !stall;
  assign instr       = instr_valid ? imem_rdata : NOP_INSTR;

  // PCsrc/ImmOp refer to the presented instruction, so they only matter when it is real.
  assign take = instr_valid && PCsrc && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr_pc <= RESET_PC;
      state    <= BOOT;
    end else if (!stall) begin
      instr_pc <= pc;
      if (take) begin
        // Target is relative to the branching instruction; the sequential fetch now in memory is dropped.
        pc    <= instr_pc + ImmOp;
        state <= SQUASH;
      end else begin
        pc    <= pc + ADDR_WIDTH'(4);
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: synchronous memory model, stream-level reference model checked every cycle, directed vectors.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .ImmOp(ImmOp), .stall(stall),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the byte address, distinct from NOP and from the address itself.
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1234_5000;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: m_valid/m_pc is what is presented; m_want is the address of the next real instruction.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_want;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_pc    <= 32'h0;
      m_want  <= 32'h0;
    end else if (!stall) begin
      if (m_valid && PCsrc) begin
        m_valid <= 1'b0;
        m_pc    <= m_pc + 32'd4;
        m_want  <= m_pc + ImmOp;
      end else begin
        m_valid <= 1'b1;
        m_pc    <= m_want;
        m_want  <= m_want + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("m_instr_pc", instr_pc, m_pc);
    chk("m_instr", instr, m_valid ? word(m_pc) : NOP);
    chk("m_imem_addr", imem_addr, m_want);
    chk("m_imem_en", {31'b0, imem_en}, {31'b0, !stall});
  end

  task automatic step(input logic br, input logic [31:0] imm, input logic st);
    PCsrc = br;
    ImmOp = imm;
    stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic see(input string name, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({name, "_valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({name, "_pc"}, instr_pc, pc);
    chk({name, "_instr"}, instr, ins);
  endtask

  initial begin
    rst = 1'b1; PCsrc = 1'b0; ImmOp = 32'h0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    see("reset", 1'b0, 32'h0, 32'h13);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_en", {31'b0, imem_en}, 32'h1);
    rst = 1'b0;

    // Sequential start-up, then branch at 8 by +16.
    step(1'b0, 32'h0, 1'b0); see("seq0", 1'b1, 32'h0, 32'h1234_5000);
    chk("seq0_addr", imem_addr, 32'h4);
    step(1'b0, 32'h0, 1'b0); see("seq4", 1'b1, 32'h4, 32'h1234_5004);
    step(1'b0, 32'h0, 1'b0); see("seq8", 1'b1, 32'h8, 32'h1234_5008);
    step(1'b1, 32'd16, 1'b0); see("bubble", 1'b0, 32'hC, 32'h13);
    step(1'b0, 32'h0, 1'b0); see("tgt24", 1'b1, 32'd24, 32'h1234_5018);
    step(1'b0, 32'h0, 1'b0); see("tgt28", 1'b1, 32'd28, 32'h1234_501C);

    // Branch at 28 by +8; PCsrc during the bubble must be ignored.
    step(1'b1, 32'd8, 1'b0);
    step(1'b1, 32'd100, 1'b0); see("sq_ignore", 1'b1, 32'd36, 32'h1234_5024);

    // Stall in RUN, with PCsrc asserted throughout.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd64, 1'b1); see("run_stall", 1'b1, 32'd36, 32'h1234_5024);
      chk("run_stall_en", {31'b0, imem_en}, 32'h0);
    end
    step(1'b0, 32'h0, 1'b0); see("run_resume", 1'b1, 32'd40, 32'h1234_5028);

    // Branch back to 0, with a 3-cycle stall inside the bubble.
    step(1'b1, 32'hFFFF_FFD8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'd4, 1'b1); see("sq_stall", 1'b0, 32'd44, 32'h13);
    end
    step(1'b0, 32'h0, 1'b0); see("sq_resume", 1'b1, 32'h0, 32'h1234_5000);

    // Backward branch wraps below zero, then sequential fetch wraps past the top.
    step(1'b1, 32'hFFFF_FFF8, 1'b0); see("wrap_bub", 1'b0, 32'h4, 32'h13);
    step(1'b0, 32'h0, 1'b0); see("wrap_neg", 1'b1, 32'hFFFF_FFF8, 32'hEDCB_AFF8);
    step(1'b0, 32'h0, 1'b0); see("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'hEDCB_AFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    step(1'b0, 32'h0, 1'b0); see("wrap_zero", 1'b1, 32'h0, 32'h1234_5000);

    // Reset asserted mid-bubble takes effect before the next edge.
    step(1'b1, 32'd12, 1'b0); see("pre_rst", 1'b0, 32'h4, 32'h13);
    rst = 1'b1;
    #1;
    see("rst_sq", 1'b0, 32'h0, 32'h13);
    chk("rst_sq_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stall in BOOT with PCsrc high: nothing lost or taken.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'd40, 1'b1); see("boot_stall", 1'b0, 32'h0, 32'h13);
    end
    step(1'b1, 32'd40, 1'b0); see("boot_go", 1'b1, 32'h0, 32'h1234_5000);
    step(1'b0, 32'h0, 1'b0); see("boot_seq", 1'b1, 32'h4, 32'h1234_5004);

    // Reset asserted mid-stall.
    step(1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    #1;
    see("rst_st", 1'b0, 32'h0, 32'h13);
    chk("rst_st_en", {31'b0, imem_en}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0); see("rst_st_go", 1'b1, 32'h0, 32'h1234_5000);
    step(1'b0, 32'h0, 1'b0); see("rst_st_seq", 1'b1, 32'h4, 32'h1234_5004);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the reduced RISC-V core, directly upstream of the control unit. Owns the program counter, drives a synchronous instruction memory, and presents one instruction per cycle, with its PC, to decode and the control unit. It applies taken-branch redirects from the control unit's `PCsrc`, using the sign-extended `ImmOp`. While a redirect is pending, it feeds a NOP (`addi x0,x0,0`) downstream, because the control unit has no valid input.

## Interface
- `ADDR_WIDTH`, 32: PC and instruction-memory address width.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: instruction driven while `instr_valid` is 0.
- `clk`  in  1  clock. Single clock domain; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `PCsrc`  in  1  from the control unit; 1 = branch taken for the instruction currently presented.
- `ImmOp`  in  ADDR_WIDTH  sign-extended branch offset for the presented instruction.
- `stall`  in  1  hold the whole stage this cycle.
- `imem_addr`  out  ADDR_WIDTH  instruction-memory read address (= PC register).
- `imem_en`  out  1  memory read enable. While `imem_en` is low, the memory holds its previous `imem_rdata`.
- `imem_rdata`  in  DATA_WIDTH  read data. Returns `mem[imem_addr]` one edge after the address is sampled with `imem_en`=1.
- `instr`  out  DATA_WIDTH  presented instruction: `imem_rdata` if `instr_valid`, else `NOP_INSTR`.
- `instr_pc`  out  ADDR_WIDTH  address of the presented instruction.
- `instr_valid`  out  1  1 = `instr` is a real fetched instruction.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `instr_pc`: address of the in-flight/presented fetch.
  - `state` ∈ {BOOT, RUN, SQUASH}.
- Outputs derived from registers:
  - `instr_valid` = (`state` == RUN).
  - `imem_addr` = `pc`.
  - `imem_en` = !`stall`.
- `take` = `instr_valid` && `PCsrc` && !`stall`. `PCsrc` and `ImmOp` are ignored whenever `instr_valid` = 0.
- On each edge with `stall` = 0:
  - `instr_pc` <= `pc`.
  - If `take`: `pc` <= `instr_pc` + `ImmOp` (branch target, relative to the branching instruction); `state` <= SQUASH.
  - Else: `pc` <= `pc` + 4; `state` <= RUN.
- SQUASH lasts exactly one cycle. The sequential fetch already in memory is discarded, and the target is fetched on the next edge.
- `stall` = 1: `pc`, `instr_pc` and `state` hold, and `imem_en` = 0, so the memory holds its data. Outputs are therefore unchanged for the whole stall, in any state.
- Arithmetic: both +4 and +`ImmOp` are modulo 2^ADDR_WIDTH (wrap silently; negative `ImmOp` gives backward branches). No alignment check; low bits pass through unchanged.

## Timing
- Reset (asynchronous, any time including mid-branch or mid-stall): `pc`=`instr_pc`=`RESET_PC`, `state`=BOOT, `instr_valid`=0, `instr`=`NOP_INSTR`, `imem_addr`=`RESET_PC`, `imem_en`=!`stall`. Any in-flight fetch is discarded.
- First edge after reset release (no stall): `instr_valid`=1, `instr`=`mem[RESET_PC]`, `instr_pc`=`RESET_PC`, `imem_addr`=`RESET_PC`+4. Fetch latency is one cycle.
- Sequential steady state: one instruction per cycle, with `instr_pc` increasing by 4.
- Taken branch at `instr_pc`=P:
  - Next cycle: `instr_valid`=0, `instr`=NOP.
  - Following cycle: `instr_valid`=1, `instr_pc`=P+`ImmOp`.
  - Penalty: exactly 1 bubble.
- Not-taken branch: no penalty.
- `stall` asserted during BOOT or SQUASH delays the transition by the stall length; no fetch is lost or duplicated.

## Test plan
- Reset, then run with memory `mem[i]`=i: `instr_pc` reads 0, 4, 8, 12 on successive cycles, and `instr` equals the matching word.
- Branch at `instr_pc`=8 with `PCsrc`=1, `ImmOp`=16: next cycle `instr`=32'h13 and `instr_valid`=0; then `instr_pc`=24, then 28.
- `ImmOp`=-8 at `instr_pc`=0 → target 32'hFFFF_FFF8. Separately, `pc`=32'hFFFF_FFFC → next fetch is 0. Both wrap.
- `stall` for 3 cycles in RUN, then in SQUASH: outputs are frozen throughout, and the sequence resumes unchanged with no skipped or duplicated `instr_pc`.
- `PCsrc`=1 while `instr_valid`=0 (BOOT, SQUASH): ignored; the sequence is unaffected.
- Assert `rst` mid-SQUASH and mid-stall: outputs go to reset values immediately (before the next edge), and the first valid fetch after release is at `RESET_PC`.
